pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 3: the maximum legal number of consecutive hazard-stall cycles before an error is flagged.
REQ-002 Parameter CNT_W, default 16: the width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 raw_ex  input  1  control-RAW stall request: branch/JALR in decode reads the destination of the ID/EX instruction.
REQ-006 raw_ldbr  input  1  load-to-branch stall request: branch/JALR in decode reads the destination of a load in EX/MEM.
REQ-007 load_use  input  1  generic load-use stall request from the ID/EX load check.
REQ-008 branch_taken  input  1  branch or JALR resolved taken in decode this cycle.
REQ-009 mem_busy  input  1  data memory is not ready; the whole pipeline must freeze.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register write enables.
REQ-011 pc_sel_tgt  output  1  selects the branch target as the next PC.
REQ-012 ifid_flush  output  1  squashes IF/ID to a NOP.
REQ-013 idex_bubble  output  1  loads a NOP into ID/EX.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  saturating counts of hazard-stall cycles and of flushes.
REQ-015 stall_err  output  1  sticky flag: a stall exceeded MAX_STALL.

Function
REQ-016 The FSM SHALL have four states: RUN, HAZ_STALL, REDIRECT and MEM_WAIT, encoded with a package enum.
REQ-017 hazard SHALL equal raw_ex | raw_ldbr | load_use.
REQ-018 Per-cycle outputs SHALL follow this priority: (1) mem_busy; (2) hazard; (3) branch_taken; (4) none of these.
REQ-019 Priority (1), mem_busy: all five enables SHALL be 0, and ifid_flush and idex_bubble SHALL be 0.
REQ-020 Priority (2), hazard: pc_en = ifid_en = 0, idex_bubble = 1, and exmem_en = memwb_en = idex_en = 1.
REQ-021 Priority (3), branch_taken: all enables SHALL be 1, pc_sel_tgt = 1 and ifid_flush = 1.
REQ-022 Priority (4), no event: all enables SHALL be 1 and all other control outputs 0.
REQ-023 All outputs SHALL be combinational, with zero latency from their inputs.
REQ-024 Transitions from RUN, HAZ_STALL or REDIRECT SHALL be: mem_busy -> MEM_WAIT; else hazard -> HAZ_STALL; else branch_taken -> REDIRECT; else -> RUN.
REQ-025 From MEM_WAIT, the FSM SHALL stay while mem_busy is 1, and otherwise re-evaluate using the REQ-024 transitions.
REQ-026 A branch_taken coincident with mem_busy SHALL be dropped; the frozen decode stage re-presents it after MEM_WAIT.
REQ-027 REDIRECT SHALL last one cycle; no second flush SHALL occur unless branch_taken is asserted again.
REQ-028 A 2-bit-minimum run counter SHALL count consecutive cycles in which hazard is asserted without mem_busy.
REQ-029 The run counter SHALL hold during mem_busy cycles and clear on any cycle in which hazard is 0 and mem_busy is 0.
REQ-030 When the run counter would exceed MAX_STALL, stall_err SHALL set and stay set until reset; the stall itself continues.
REQ-031 stall_cnt SHALL increment on every cycle in which idex_bubble = 1.
REQ-032 flush_cnt SHALL increment on every cycle in which ifid_flush = 1.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.
REQ-034 A registered run_ok flop SHALL gate all outputs; while run_ok = 0, every enable, pc_sel_tgt, ifid_flush and idex_bubble SHALL be 0.

Reset
REQ-035 While rst_n = 0: state = RUN, run_ok = 0, run counter = 0, stall_cnt = flush_cnt = 0, stall_err = 0, and all control outputs = 0.
REQ-036 On the first rising clk edge after rst_n rises, run_ok SHALL become 1; normal operation starts that cycle.
REQ-037 A reset asserted mid-stall or mid-MEM_WAIT SHALL abort the stall immediately, asynchronously, with no residual bubble afterwards.

Structure
REQ-038 The state enum and the default MAX_STALL SHALL live in common_def, next to the existing opcode constants.
REQ-039 The saturating counter SHALL be a single sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated twice.
REQ-040 The hazard request inputs SHALL come from CheckForControlToUse instances and the load-use checker; this block performs no register comparisons.

Verification
REQ-041 Directed test: raw_ex = 1 for 1 cycle -> idex_bubble = 1 and pc_en = 0 for exactly 1 cycle, stall_cnt = 1, state HAZ_STALL then RUN.
REQ-042 Directed test: raw_ldbr for 2 cycles then raw_ex for 1 cycle (3 consecutive) -> 3 bubbles, stall_cnt = 3, stall_err = 0; a 4th consecutive cycle -> stall_err = 1, which persists.
REQ-043 Directed test: branch_taken and raw_ex in the same cycle -> bubble only, no flush, flush_cnt = 0; branch_taken the next cycle alone -> ifid_flush = 1 and pc_sel_tgt = 1, flush_cnt = 1.
REQ-044 Directed test: mem_busy for 5 cycles during hazard = 1 -> all enables 0 for 5 cycles, stall_cnt unchanged, run counter held; after release the stall resumes.
REQ-045 Directed test: preload stall_cnt to 0xFFFE, then apply 3 hazard cycles -> stall_cnt = 0xFFFF, no wrap.
REQ-046 Directed test: rst_n pulled low mid-HAZ_STALL -> outputs go to 0 immediately; 1 cycle after release, pc_en = 1 and counters = 0.

Source files
------------

// File: rtl/common_def.sv
// Shared decode constants and hazard-control types for the pipeline control slice.
package common_def;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam int unsigned MAX_STALL_DEF = 3;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        REDIRECT  = 2'd2,
        MEM_WAIT  = 2'd3
    } hz_state_e;

    // Run counter must reach max_stall; never narrower than 2 bits.
    function automatic int unsigned run_cnt_width(input int unsigned max_stall);
        int unsigned w;
        w = $clog2(max_stall + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze enables, hazard FSM, stall watchdog and perf counters.
module pipe_hazard_ctrl
    import common_def::*;
#(
    parameter int unsigned MAX_STALL = MAX_STALL_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_ex,
    input  logic             raw_ldbr,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             pc_sel_tgt,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    localparam int unsigned RUN_W = run_cnt_width(MAX_STALL);

    hz_state_e        state_q, state_d, evt_state;
    logic             run_ok_q;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             stall_err_q, stall_err_d;
    logic             hazard;

    assign hazard = raw_ex | raw_ldbr | load_use;

    // Outputs depend only on current requests; run_ok keeps everything quiet until reset has cleared.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        pc_sel_tgt  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (run_ok_q && !mem_busy) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (hazard) begin
                idex_bubble = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                if (branch_taken) begin
                    pc_sel_tgt = 1'b1;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (mem_busy) begin
            evt_state = MEM_WAIT;
        end else if (hazard) begin
            evt_state = HAZ_STALL;
        end else if (branch_taken) begin
            evt_state = REDIRECT;
        end else begin
            evt_state = RUN;
        end

        state_d = state_q;
        case (state_q)
            MEM_WAIT: state_d = mem_busy ? MEM_WAIT : evt_state;
            default:  state_d = evt_state;
        endcase
        if (!run_ok_q) begin
            state_d = RUN;
        end
    end

    // Run counter freezes with the pipeline during mem_busy; at the limit it holds and the error latches.
    always_comb begin
        run_cnt_d   = run_cnt_q;
        stall_err_d = stall_err_q;
        if (run_ok_q && !mem_busy) begin
            if (hazard) begin
                if (run_cnt_q == RUN_W'(MAX_STALL)) begin
                    stall_err_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end else begin
                run_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            run_ok_q    <= 1'b0;
            run_cnt_q   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_ok_q    <= 1'b1;
            run_cnt_q   <= run_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (idex_bubble),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle reference model plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;
    import common_def::*;

    localparam int MAXS    = 3;
    localparam int CNT_MAX = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_ex = 1'b0, raw_ldbr = 1'b0, load_use = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic pc_sel_tgt, ifid_flush, idex_bubble, stall_err;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.MAX_STALL(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_ex       (raw_ex),
        .raw_ldbr     (raw_ldbr),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .pc_sel_tgt   (pc_sel_tgt),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .stall_err    (stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ok flag, consecutive-hazard count, counters as plain integers.
    int        m_stall, m_flush, m_consec;
    bit        m_err, m_ok;
    hz_state_e m_state;

    function automatic bit f_haz();
        return raw_ex | raw_ldbr | load_use;
    endfunction

    // {pc, ifid, idex, exmem, memwb}
    function automatic logic [4:0] f_en();
        if (!m_ok || mem_busy) return 5'b00000;
        if (f_haz()) return 5'b00111;
        return 5'b11111;
    endfunction

    function automatic bit f_bub();
        return m_ok && !mem_busy && f_haz();
    endfunction

    function automatic bit f_fl();
        return m_ok && !mem_busy && !f_haz() && branch_taken;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stall = 0; m_flush = 0; m_consec = 0;
            m_err = 1'b0; m_ok = 1'b0; m_state = RUN;
        end else begin
            if (f_bub() && m_stall < CNT_MAX) m_stall = m_stall + 1;
            if (f_fl() && m_flush < CNT_MAX) m_flush = m_flush + 1;
            if (m_ok && !mem_busy) begin
                if (f_haz()) begin
                    m_consec = m_consec + 1;
                    if (m_consec > MAXS) m_err = 1'b1;
                end else begin
                    m_consec = 0;
                end
            end
            if (!m_ok)                m_state = RUN;
            else if (mem_busy)        m_state = MEM_WAIT;
            else if (f_haz())         m_state = HAZ_STALL;
            else if (branch_taken)    m_state = REDIRECT;
            else                      m_state = RUN;
            m_ok = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), int'(f_en()));
        chk("pc_sel_tgt", int'(pc_sel_tgt), int'(f_fl()));
        chk("ifid_flush", int'(ifid_flush), int'(f_fl()));
        chk("idex_bubble", int'(idex_bubble), int'(f_bub()));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
        chk("stall_err", int'(stall_err), int'(m_err));
        chk("state", int'(dut.state_q), int'(m_state));
        chk("run_cnt", int'(dut.run_cnt_q), (m_consec > MAXS) ? MAXS : m_consec);
    end

    // {raw_ex, raw_ldbr, load_use, branch_taken, mem_busy}
    task automatic drv(input logic [4:0] v);
        {raw_ex, raw_ldbr, load_use, branch_taken, mem_busy} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        drv(5'b00000);
        repeat (3) tick();
        chk("reset_pc_en", int'(pc_en), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        rst_n = 1'b1;
        tick();
        chk("first_run_pc_en", int'(pc_en), 1);

        // single control-RAW stall
        drv(5'b10000); #2;
        chk("raw1_bubble", int'(idex_bubble), 1);
        chk("raw1_pc_en", int'(pc_en), 0);
        tick();
        chk("raw1_state", int'(dut.state_q), int'(HAZ_STALL));
        chk("raw1_stall_cnt", int'(stall_cnt), 1);
        drv(5'b00000); #2;
        chk("raw1_after_bubble", int'(idex_bubble), 0);
        tick();
        chk("raw1_state_run", int'(dut.state_q), int'(RUN));

        // three consecutive stalls are legal, the fourth flags the error
        drv(5'b01000); tick(); tick();
        drv(5'b10000); tick();
        chk("run3_stall_cnt", int'(stall_cnt), 4);
        chk("run3_err", int'(stall_err), 0);
        drv(5'b00100); tick();
        chk("run4_err", int'(stall_err), 1);
        chk("run4_stall_cnt", int'(stall_cnt), 5);
        drv(5'b00000); tick(); tick();
        chk("err_sticky", int'(stall_err), 1);

        // hazard beats branch; branch alone redirects
        drv(5'b10010); #2;
        chk("hb_flush", int'(ifid_flush), 0);
        chk("hb_bubble", int'(idex_bubble), 1);
        tick();
        chk("hb_flush_cnt", int'(flush_cnt), 0);
        drv(5'b00010); #2;
        chk("br_flush", int'(ifid_flush), 1);
        chk("br_sel", int'(pc_sel_tgt), 1);
        tick();
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_state", int'(dut.state_q), int'(REDIRECT));
        drv(5'b00000); #2;
        chk("br_no_reflush", int'(ifid_flush), 0);
        tick();

        // memory freeze in the middle of a stall
        drv(5'b00100); tick();
        chk("mw_pre_stall_cnt", int'(stall_cnt), 7);
        drv(5'b00101);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("mw_enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 0);
            tick();
        end
        chk("mw_stall_cnt", int'(stall_cnt), 7);
        chk("mw_run_held", int'(dut.run_cnt_q), 1);
        chk("mw_state", int'(dut.state_q), int'(MEM_WAIT));
        drv(5'b00100); tick();
        chk("mw_resume_stall_cnt", int'(stall_cnt), 8);
        chk("mw_resume_run", int'(dut.run_cnt_q), 2);
        drv(5'b00011); tick();
        chk("mw_br_dropped", int'(flush_cnt), 1);
        drv(5'b00010); tick();
        chk("mw_br_replayed", int'(flush_cnt), 2);
        drv(5'b00000); tick();
        chk("mw_br_once", int'(flush_cnt), 2);

        // saturation of stall_cnt
        drv(5'b00100);
        repeat (65534 - 8) tick();
        chk("sat_preload", int'(stall_cnt), 16'hFFFE);
        repeat (3) tick();
        chk("sat_hold", int'(stall_cnt), 16'hFFFF);
        drv(5'b00000); tick();

        // asynchronous reset mid-stall
        drv(5'b00100); tick();
        chk("rst_pre_state", int'(dut.state_q), int'(HAZ_STALL));
        #2; rst_n = 1'b0; #1;
        chk("rst_enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 0);
        chk("rst_bubble", int'(idex_bubble), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_err", int'(stall_err), 0);
        drv(5'b00000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc_en", int'(pc_en), 1);
        chk("post_rst_bubble", int'(idex_bubble), 0);
        chk("post_rst_counts", int'(stall_cnt) + int'(flush_cnt), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
